// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator-side controller for a word-only data memory. Accepts byte,
//   halfword and word loads/stores from the datapath, returns loads sign- or
//   zero-extended, and performs sub-word stores as read-modify-write.
//   Misaligned or out-of-range requests complete with err=1 and never touch
//   memory.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req, we, size, sign_ext      request strobe and its attributes (IDLE only)
//   addr, wdata                  byte address, right-aligned store data
//   rdata                        load result, held until the next load completes
//   busy, done, err              status: not idle / end-of-request pulse / error
//   MemRead, MemWrite            memory enables (decoded from state)
//   address, writeData           word-aligned memory address and full write word
//   readData                     combinational memory read data
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nx;
    logic        we_q, sext_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [15:0] wdata_q;   // only the sub-word part is needed after IDLE

    logic        req_err;
    logic [31:0] merged, extracted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Request validity: size 11 behaves as a word.
    always_comb begin
        req_err = 1'b0;
        if (size == 2'b01 && addr[0])
            req_err = 1'b1;
        if (size[1] && addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (addr >= MEM_LIMIT)
            req_err = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_err)
                        state_nx = DONE;
                    else if (we && size[1])
                        state_nx = WRITE;
                    else
                        state_nx = READ;  // loads and sub-word RMW stores
                end
            end
            READ:    state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Little-endian lane extract and merge against the captured read word.
    always_comb begin
        byte_v = readData[{lane_q, 3'b000} +: 8];
        half_v = readData[{lane_q[1], 4'b0000} +: 16];

        merged = readData;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;

        case (size_q)
            2'b00:   extracted = {{24{sext_q & byte_v[7]}}, byte_v};
            2'b01:   extracted = {{16{sext_q & half_v[15]}}, half_v};
            default: extracted = readData;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            address   <= '0;
            writeData <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        err_q   <= req_err;
                        address <= {addr[ADDR_W-1:2], 2'b00};
                        if (!req_err && we && size[1])
                            writeData <= wdata;
                    end
                end
                READ: begin
                    if (we_q)
                        writeData <= merged;
                    else
                        rdata <= extracted;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = (state == DONE) && err_q;
    assign MemRead  = (state == READ);
    assign MemWrite = (state == WRITE);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side controller that drives the word-only data memory port (MemRead, MemWrite, address, writeData, readData) on behalf of the datapath. It accepts byte, halfword and word load/store requests. Loads are returned sign- or zero-extended. Sub-word stores are done as a read-modify-write sequence, because the memory only writes full 32-bit words. It sits between the MIPS execute/mem stage and DataMemory, and reports alignment and range errors without touching memory.

Parameters:
ADDR_W, 32, width of request and memory address.
MEM_BYTES, 1024, size of the addressable data memory in bytes (256 words); addresses >= MEM_BYTES are errors.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  1  request strobe, sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
addr  input  ADDR_W  byte address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rdata  output  32  load result, valid while done=1, held until next load completes
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of every accepted request
err  output  1  valid with done; 1 = misaligned or out-of-range, no memory access made
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
address  output  ADDR_W  word-aligned memory address ([1:0] forced 00)
writeData  output  32  full word to write
readData  input  32  combinational memory read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rdata, address, writeData=0; busy, done, err, MemRead, MemWrite=0. Outputs clear immediately, not at the next edge.
- States: IDLE, READ, WRITE, DONE.
- MemRead=1 only in READ; MemWrite=1 only in WRITE; both decoded from state, never both high.
- On req=1 in IDLE, latch we/size/sign_ext/addr/wdata and set address={addr[ADDR_W-1:2],2'b00}.
- Error check, evaluated in IDLE:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]!=0 is misaligned;
  - addr >= MEM_BYTES is out of range.
  - On error: go to DONE with err=1; MemRead/MemWrite never assert; rdata unchanged.
- Transitions from IDLE:
  - load -> READ;
  - store word -> WRITE, with writeData=wdata;
  - store byte/half -> READ.
- READ: capture readData at the end of the cycle.
  - Load: extract the lane into rdata, then -> DONE.
  - Sub-word store: merge wdata into the captured word, put the result on writeData, then -> WRITE.
- WRITE: one cycle, then -> DONE.
- DONE: done=1 for one cycle, err valid, then -> IDLE.
- Lanes are little-endian: byte k = bits [8k+7:8k] with k=addr[1:0]; half h = bits [16h+15:16h] with h=addr[1]. A merge replaces only the selected lane; all other bits come from readData.
- Extension: byte/half loads extend from bit 7/15 when sign_ext=1, otherwise zero-fill. Word loads pass through unchanged.
- Latency, counted from the edge that samples req to the cycle with done=1:
  - load: 2 cycles;
  - store word: 2 cycles;
  - store byte/half: 3 cycles;
  - error: 1 cycle.
- req while busy (including DONE) is ignored, not queued. Back-to-back operation: the earliest next acceptance is the cycle after DONE.
- Reset mid-operation aborts to IDLE. If reset_n falls before the WRITE-cycle edge, no memory write occurs.
- address and writeData hold their last values in IDLE.

Test Plan:
- Store word 0xDEADBEEF at 0x10 -> MemWrite high for exactly 1 cycle with address=0x10, writeData=0xDEADBEEF; done 2 cycles after req, err=0.
- Load byte 0x13 with sign_ext=1 -> rdata=0xFFFFFFDE; lbu 0x10 -> 0x000000EF; lhu 0x12 -> 0x0000DEAD; lh 0x10 -> 0xFFFFBEEF.
- Store byte 0x5A at 0x11 -> one READ cycle, then WRITE with writeData=0xDEAD5AEF; done at 3 cycles; a following word load at 0x10 returns 0xDEAD5AEF.
- Load half at 0x11, then store word at 0x402 and load byte at 0x400 -> err=1, done after 1 cycle each; MemRead/MemWrite stay 0; rdata unchanged.
- Pulse req during READ of a load -> ignored; only one done pulse; busy stays high until DONE completes.
- Assert reset_n=0 mid-READ of a store byte to 0x14 -> MemRead drops immediately; no MemWrite ever; word at 0x14 unchanged; all outputs 0.
